// File: rtl/pll_ddr2_rst_seq_pkg.sv
// Shared constants, state encodings and saturating-increment helpers for the
// DDR PLL reset/lock sequencer.
package pll_seq_pkg;

  localparam int DEF_RST_CYCLES          = 50;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1000;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_MAX_RETRIES         = 7;

  localparam int ATTEMPT_W = 4;
  localparam int RESTART_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_PLL_RST   = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_STABLE    = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_FAULT     = 3'd4;

  // Diagnostic counters stick at all-ones rather than wrapping.
  function automatic logic [ATTEMPT_W-1:0] attempt_inc(input logic [ATTEMPT_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  function automatic logic [RESTART_W-1:0] restart_inc(input logic [RESTART_W-1:0] r);
    return (&r) ? r : r + 1'b1;
  endfunction

endpackage

// File: rtl/pll_ddr2_rst_seq_sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ddr2_rst_seq.sv
// DDR PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases
// the DDR reset after a stable interval, and retries or faults on failure.
module pll_ddr2_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES          = DEF_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 pll_lock,
  input  logic                 rearm,
  output logic                 pll_reset,
  output logic                 ddr_reset,
  output logic                 ready,
  output logic                 fault,
  output logic                 lock_lost,
  output logic [ATTEMPT_W-1:0] attempts,
  output logic [RESTART_W-1:0] restarts
);

  localparam int SEQ_MAX = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [SEQ_W-1:0]     RST_END    = SEQ_W'(RST_CYCLES);
  localparam logic [SEQ_W-1:0]     STABLE_END = SEQ_W'(LOCK_STABLE_CYCLES);
  localparam logic [TO_W-1:0]      TO_END     = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [ATTEMPT_W-1:0] RETRY_MAX  = ATTEMPT_W'(MAX_RETRIES);

  logic lock_s;

  state_t               state, state_n;
  logic [SEQ_W-1:0]     cnt, cnt_n;
  logic [TO_W-1:0]      tcnt, tcnt_n;
  logic [ATTEMPT_W-1:0] attempts_n;
  logic [RESTART_W-1:0] restarts_n;
  logic                 lock_lost_n;
  logic                 fail;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // cnt times the reset pulse, then the stable-lock run. Retry and rearm
  // entries preload 1 so every pulse is RST_CYCLES wide; after reset it starts
  // at 0, so the first pulse ends RST_CYCLES edges after reset is released.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tcnt_n      = tcnt;
    attempts_n  = attempts;
    restarts_n  = restarts;
    lock_lost_n = lock_lost;
    fail        = 1'b0;

    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_END) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
          tcnt_n  = '0;
        end else begin
          cnt_n = cnt + SEQ_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (tcnt == TO_END) begin
          fail = 1'b1;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
          if (lock_s) begin
            state_n = ST_STABLE;
            cnt_n   = '0;
          end
        end
      end
      ST_STABLE: begin
        // Timeout is checked first so it wins over a coincident final count.
        if (tcnt == TO_END) begin
          fail = 1'b1;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
          if (!lock_s) begin
            state_n = ST_WAIT_LOCK;
          end else if (cnt == STABLE_END) begin
            state_n    = ST_RUN;
            attempts_n = '0;
          end else begin
            cnt_n = cnt + SEQ_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_n     = ST_PLL_RST;
          cnt_n       = SEQ_W'(1);
          lock_lost_n = 1'b1;
          restarts_n  = restart_inc(restarts);
          attempts_n  = ATTEMPT_W'(1);
        end
      end
      ST_FAULT: begin
        if (rearm) begin
          state_n    = ST_PLL_RST;
          cnt_n      = SEQ_W'(1);
          attempts_n = '0;
        end
      end
      default: begin
        state_n = ST_PLL_RST;
        cnt_n   = SEQ_W'(1);
      end
    endcase

    if (fail) begin
      attempts_n = attempt_inc(attempts);
      if (attempts_n >= RETRY_MAX) begin
        state_n = ST_FAULT;
      end else begin
        state_n    = ST_PLL_RST;
        cnt_n      = SEQ_W'(1);
        restarts_n = restart_inc(restarts);
      end
    end
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      tcnt      <= '0;
      attempts  <= '0;
      restarts  <= '0;
      lock_lost <= 1'b0;
      pll_reset <= 1'b1;
      ddr_reset <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tcnt      <= tcnt_n;
      attempts  <= attempts_n;
      restarts  <= restarts_n;
      lock_lost <= lock_lost_n;
      pll_reset <= (state_n == ST_PLL_RST) || (state_n == ST_FAULT);
      ddr_reset <= (state_n != ST_RUN);
      ready     <= (state_n == ST_RUN);
      fault     <= (state_n == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_ddr2_rst_seq.sv
// Directed bench for pll_ddr2_rst_seq: the driver queues expected output
// vectors tagged with the edge number at which they must appear.
module tb_pll_ddr2_rst_seq;

  localparam int W = 33;  // {edge[15:0], output vector[16:0]}

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       rearm;
  logic       pll_reset;
  logic       ddr_reset;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] attempts;
  logic [7:0] restarts;

  logic [W-1:0] exp_q[$];
  int           cyc;
  int           checks;
  int           errors;
  logic         mon_en;
  logic [16:0]  prev;

  pll_ddr2_rst_seq #(
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (3)
  ) dut (
    .clkin     (clk),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .rearm     (rearm),
    .pll_reset (pll_reset),
    .ddr_reset (ddr_reset),
    .ready     (ready),
    .fault     (fault),
    .lock_lost (lock_lost),
    .attempts  (attempts),
    .restarts  (restarts)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] ov(input logic pr, input logic dr, input logic rdy,
                                     input logic flt, input logic ll,
                                     input logic [3:0] att, input logic [7:0] rs);
    return {pr, dr, rdy, flt, ll, att, rs};
  endfunction

  // Driver tasks: all are entered just after a falling edge
  task automatic push_exp(input int c, input logic [16:0] v);
    exp_q.push_back({16'(c), v});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(output int r);
    r = cyc + 1;
    push_exp(r, ov(1, 1, 0, 0, 0, 4'd0, 8'd0));
    mon_en = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  // Scoreboard monitor: compares at tagged edges, flags any untagged change
  always @(posedge clk) begin
    logic [16:0]  cur;
    logic [W-1:0] head;
    #1;
    cur = {pll_reset, ddr_reset, ready, fault, lock_lost, attempts, restarts};
    head = '0;
    if (exp_q.size() > 0) head = exp_q[0];
    if (exp_q.size() > 0 && head[32:17] == 16'(cyc)) begin
      void'(exp_q.pop_front());
      checks++;
      if (cur !== head[16:0]) begin
        errors++;
        $display("FAIL outputs@edge%0d: got {pr,dr,rdy,flt,ll,att,rst}=%b exp %b",
                 cyc, cur, head[16:0]);
      end
    end else if (mon_en && cur !== prev) begin
      checks++;
      errors++;
      $display("FAIL unexpected_change@edge%0d: got %b, required unchanged %b", cyc, cur, prev);
    end
    prev = cur;
  end

  initial begin
    int r1, r2, r3, r6, r4, r5;
    logic [W-1:0] e;
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    pll_lock = 1'b0;
    rearm    = 1'b0;
    @(negedge clk);

    // Nominal, then lock loss in RUN, then rearm ignored in RUN
    do_reset(r1);
    push_exp(r1 + 5,  ov(0, 1, 0, 0, 0, 4'd0, 8'd0));
    push_exp(r1 + 26, ov(0, 0, 1, 0, 0, 4'd0, 8'd0));
    push_exp(r1 + 40, ov(0, 0, 1, 0, 0, 4'd0, 8'd0));
    push_exp(r1 + 43, ov(1, 1, 0, 0, 1, 4'd1, 8'd1));
    push_exp(r1 + 47, ov(0, 1, 0, 0, 1, 4'd1, 8'd1));
    push_exp(r1 + 57, ov(0, 0, 1, 0, 1, 4'd0, 8'd1));
    push_exp(r1 + 63, ov(0, 0, 1, 0, 1, 4'd0, 8'd1));
    wait_cyc(r1 + 14); pll_lock = 1'b1;
    wait_cyc(r1 + 40); pll_lock = 1'b0;
    wait_cyc(r1 + 41); pll_lock = 1'b1;
    wait_cyc(r1 + 60); rearm = 1'b1;
    wait_cyc(r1 + 61); rearm = 1'b0;
    wait_cyc(r1 + 65);

    // Lock chatter: 5 high, 1 low, then high; reset also clears lock_lost
    pll_lock = 1'b0;
    do_reset(r2);
    push_exp(r2 + 5,  ov(0, 1, 0, 0, 0, 4'd0, 8'd0));
    push_exp(r2 + 24, ov(0, 0, 1, 0, 0, 4'd0, 8'd0));
    push_exp(r2 + 40, ov(0, 0, 1, 0, 0, 4'd0, 8'd0));
    wait_cyc(r2 + 6);  pll_lock = 1'b1;
    wait_cyc(r2 + 11); pll_lock = 1'b0;
    wait_cyc(r2 + 12); pll_lock = 1'b1;
    wait_cyc(r2 + 42);

    // Reset pulse while in STABLE restarts from PLL_RST
    do_reset(r3);
    push_exp(r3 + 5, ov(0, 1, 0, 0, 0, 4'd0, 8'd0));
    wait_cyc(r3 + 9);
    do_reset(r6);
    push_exp(r6 + 5,  ov(0, 1, 0, 0, 0, 4'd0, 8'd0));
    push_exp(r6 + 15, ov(0, 0, 1, 0, 0, 4'd0, 8'd0));
    wait_cyc(r6 + 18);

    // Lock stuck low: three pulses, fault; then rearm and lock
    pll_lock = 1'b0;
    do_reset(r4);
    push_exp(r4 + 5,   ov(0, 1, 0, 0, 0, 4'd0, 8'd0));
    push_exp(r4 + 37,  ov(1, 1, 0, 0, 0, 4'd1, 8'd1));
    push_exp(r4 + 41,  ov(0, 1, 0, 0, 0, 4'd1, 8'd1));
    push_exp(r4 + 73,  ov(1, 1, 0, 0, 0, 4'd2, 8'd2));
    push_exp(r4 + 77,  ov(0, 1, 0, 0, 0, 4'd2, 8'd2));
    push_exp(r4 + 109, ov(1, 1, 0, 1, 0, 4'd3, 8'd2));
    push_exp(r4 + 130, ov(1, 1, 0, 1, 0, 4'd3, 8'd2));
    push_exp(r4 + 131, ov(1, 1, 0, 0, 0, 4'd0, 8'd2));
    push_exp(r4 + 135, ov(0, 1, 0, 0, 0, 4'd0, 8'd2));
    push_exp(r4 + 148, ov(0, 0, 1, 0, 0, 4'd0, 8'd2));
    wait_cyc(r4 + 130); rearm = 1'b1;
    wait_cyc(r4 + 131); rearm = 1'b0;
    wait_cyc(r4 + 136); pll_lock = 1'b1;
    wait_cyc(r4 + 150);

    // Final stable count lands on the timeout edge: timeout wins
    pll_lock = 1'b0;
    do_reset(r5);
    push_exp(r5 + 5,  ov(0, 1, 0, 0, 0, 4'd0, 8'd0));
    push_exp(r5 + 37, ov(1, 1, 0, 0, 0, 4'd1, 8'd1));
    push_exp(r5 + 41, ov(0, 1, 0, 0, 0, 4'd1, 8'd1));
    push_exp(r5 + 51, ov(0, 0, 1, 0, 0, 4'd0, 8'd1));
    wait_cyc(r5 + 25); pll_lock = 1'b1;
    wait_cyc(r5 + 54);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing@edge%0d: required %b never observed", e[32:17], e[16:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
